// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle: NUM_SRC input streams plus the single arbitrated output stream.
interface stream_rr_arbiter_if #(
  parameter int DATA_WD = 4,
  parameter int NUM_SRC = 4,
  parameter int ID_WD   = 2
);
  logic [NUM_SRC-1:0]         s_valid;
  logic [NUM_SRC*DATA_WD-1:0] s_data;
  logic [NUM_SRC-1:0]         s_last;
  logic [NUM_SRC-1:0]         s_ready;
  logic                       m_valid;
  logic [DATA_WD-1:0]         m_data;
  logic                       m_last;
  logic [ID_WD-1:0]           m_id;
  logic                       m_ready;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_id
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_id
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet round-robin arbiter onto one registered output; grant held first..last beat, one IDLE bubble per packet.
// STREAM_ARB_STATS_EN adds pkt_cnt (16-bit completed-packet counter); backpressure: held output beat stalls the grantee.
module stream_rr_arbiter #(
  parameter int DATA_WD = 4,
  parameter int NUM_SRC = 4,
  parameter int ID_WD   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_rr_arbiter_if.master bus
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [15:0]         pkt_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [ID_WD-1:0]   gnt, gnt_nxt;
  logic [ID_WD-1:0]   ptr, ptr_nxt;
  logic [ID_WD-1:0]   pick, cand;
  logic               any_req;
  logic               out_rdy;
  logic               accept;
  logic               beat_vld;
  logic               beat_last;
  logic [DATA_WD-1:0] beat_data;

  // ptr + off modulo NUM_SRC; off ranges 1..NUM_SRC so one subtraction suffices.
  function automatic logic [ID_WD-1:0] wrap_idx(input logic [ID_WD-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return sum[ID_WD-1:0];
  endfunction

  assign out_rdy = !bus.m_valid || bus.m_ready;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = wrap_idx(ptr, k);
      if (bus.s_valid[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    beat_vld  = 1'b0;
    beat_last = 1'b0;
    beat_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt == i[ID_WD-1:0]) begin
        beat_vld  = bus.s_valid[i];
        beat_last = bus.s_last[i];
        beat_data = bus.s_data[i*DATA_WD +: DATA_WD];
      end
    end
  end

  always_comb begin
    bus.s_ready = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        bus.s_ready[i] = out_rdy && (gnt == i[ID_WD-1:0]);
      end
    end
  end

  assign accept = (state == BUSY) && beat_vld && out_rdy;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nxt   = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Only the last beat releases the grant; a silent grantee stalls the arbiter.
        if (accept && beat_last) begin
          ptr_nxt   = gnt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= ID_WD'(NUM_SRC - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      bus.m_id    <= '0;
    end else if (accept) begin
      bus.m_valid <= 1'b1;
      bus.m_data  <= beat_data;
      bus.m_last  <= beat_last;
      bus.m_id    <= gnt;
    end else if (bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end

`ifdef STREAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (accept && beat_last) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: per-source beat queues, output beat log, hand-computed expectations.
module tb_stream_rr_arbiter;
  localparam int DW = 4;
  localparam int NS = 4;
  localparam int IW = 2;

  typedef struct {
    int            cyc;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.DATA_WD(DW), .NUM_SRC(NS), .ID_WD(IW)) bus();
`ifdef STREAM_ARB_STATS_EN
  logic [15:0] pkt_cnt;
`endif

  stream_rr_arbiter #(.DATA_WD(DW), .NUM_SRC(NS), .ID_WD(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STREAM_ARB_STATS_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc;
  int            ready_viol = 0;
  logic [DW:0]   srcq[NS][$];
  logic [NS-1:0] fire;
  logic [NS-1:0] hold;
  logic          mr;
  beat_t         log_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int src, input int data, input int last);
    srcq[src].push_back({last[0], data[DW-1:0]});
  endtask

  // One clock: retire beats accepted last cycle, drive the next ones, then sample.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        bus.s_valid[i]           = 1'b1;
        bus.s_data[i*DW +: DW]   = srcq[i][0][DW-1:0];
        bus.s_last[i]            = srcq[i][0][DW];
      end else begin
        bus.s_valid[i]           = 1'b0;
        bus.s_data[i*DW +: DW]   = '0;
        bus.s_last[i]            = 1'b0;
      end
    end
    bus.m_ready = mr;
    #1;
    fire = bus.s_valid & bus.s_ready;
    if ($countones(bus.s_ready) > 1) ready_viol++;
    if (bus.m_valid && bus.m_ready) log_q.push_back('{cyc, bus.m_id, bus.m_data, bus.m_last});
  endtask

  task automatic clear_stim();
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b1;
    mr          = 1'b1;
    hold        = '0;
    fire        = '0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    log_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_stim();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  task automatic chk_beat(input string tag, input int k, input int id, input int data, input int last);
    if (k < log_q.size())
      check(tag, {log_q[k].id, log_q[k].data, log_q[k].last}, {id[IW-1:0], data[DW-1:0], last[0]});
    else
      check({tag, "_missing"}, log_q.size(), k + 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t2_id[10]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int t2_data[10] = '{0, 1, 4, 5, 8, 9, 12, 13, 2, 3};
    int other_rdy;
    int found;

    // Reset state
    rst_n = 1'b0;
    clear_stim();
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data",  bus.m_data,  0);
    check("rst_m_last",  bus.m_last,  0);
    check("rst_m_id",    bus.m_id,    0);
    check("rst_s_ready", bus.s_ready, 0);
`ifdef STREAM_ARB_STATS_EN
    check("rst_pkt_cnt", pkt_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;

    // Single 3-beat packet from source 1
    push(1, 1, 0); push(1, 2, 0); push(1, 3, 1);
    cycle();
    check("t1_c0_s_ready", bus.s_ready, 4'b0000);
    check("t1_c0_m_valid", bus.m_valid, 0);
    cycle();
    check("t1_c1_s_ready", bus.s_ready, 4'b0010);
    other_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if ((bus.s_ready & 4'b1101) != 0) other_rdy++;
      check($sformatf("t1_c%0d_out", k + 2), {bus.m_valid, bus.m_id, bus.m_data, bus.m_last},
            {1'b1, 2'd1, 4'(k + 1), 1'(k == 2)});
    end
    cycle();
    if ((bus.s_ready & 4'b1101) != 0) other_rdy++;
    check("t1_c5_m_valid", bus.m_valid, 0);
    check("t1_other_ready", other_rdy, 0);

    // All sources requesting: round robin 0,1,2,3,0 with one bubble per packet
    do_reset();
    push(0, 0, 0); push(0, 1, 1); push(0, 2, 0); push(0, 3, 1);
    push(1, 4, 0); push(1, 5, 1);
    push(2, 8, 0); push(2, 9, 1);
    push(3, 12, 0); push(3, 13, 1);
    repeat (18) cycle();
    check("t2_nbeats", log_q.size(), 10);
    for (int k = 0; k < 10; k++) begin
      chk_beat($sformatf("t2_beat%0d", k), k, t2_id[k], t2_data[k], k % 2);
      if (k < log_q.size())
        check($sformatf("t2_cyc%0d", k), log_q[k].cyc, 2 + 3 * (k / 2) + (k % 2));
    end

    // Backpressure: m_ready low for 3 cycles after the second beat
    do_reset();
    push(2, 5, 0); push(2, 6, 0); push(2, 7, 0); push(2, 8, 1);
    repeat (3) cycle();
    mr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("t3_stall%0d_out", k), {bus.m_valid, bus.m_data}, {1'b1, 4'd6});
      check($sformatf("t3_stall%0d_rdy", k), bus.s_ready, 4'b0000);
    end
    mr = 1'b1;
    repeat (5) cycle();
    check("t3_nbeats", log_q.size(), 4);
    for (int k = 0; k < 4; k++) chk_beat($sformatf("t3_beat%0d", k), k, 2, 5 + k, k == 3);
    check("t3_idle", bus.m_valid, 0);

    // Grantee goes silent mid-packet; source 3 must wait
    do_reset();
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 1);
    push(3, 9, 1);
    repeat (2) cycle();
    hold[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("t4_hold%0d_rdy", k), bus.s_ready, 4'b0001);
    end
    hold[0] = 1'b0;
    repeat (8) cycle();
    check("t4_nbeats", log_q.size(), 4);
    chk_beat("t4_beat0", 0, 0, 1, 0);
    chk_beat("t4_beat1", 1, 0, 2, 0);
    chk_beat("t4_beat2", 2, 0, 3, 1);
    chk_beat("t4_beat3", 3, 3, 9, 1);

    // Reset pulse while beat 2 of a 4-beat packet sits on the output
    do_reset();
    push(1, 1, 1);
    push(2, 1, 0); push(2, 2, 0); push(2, 3, 0); push(2, 4, 1);
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      cycle();
      if (bus.m_valid && bus.m_id == 2'd2 && bus.m_data == 4'd2) found = 1;
    end
    check("t5_reach_beat2", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_m_valid", bus.m_valid, 0);
    check("t5_m_data",  bus.m_data,  0);
    check("t5_m_last",  bus.m_last,  0);
    check("t5_m_id",    bus.m_id,    0);
    check("t5_s_ready", bus.s_ready, 0);
    clear_stim();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;
    push(2, 11, 1);
    push(0, 10, 1);
    repeat (8) cycle();
    check("t5_nbeats", log_q.size(), 2);
    chk_beat("t5_beat0", 0, 0, 10, 1);
    chk_beat("t5_beat1", 1, 2, 11, 1);

`ifdef STREAM_ARB_STATS_EN
    begin
      int n_pkt;
      int guard;
      do_reset();
      n_pkt = 0;
      guard = 0;
      @(negedge clk);
      bus.s_valid = 4'b0001;
      bus.s_last  = 4'b0001;
      bus.s_data  = '0;
      while (n_pkt < 65537 && guard < 200000) begin
        @(negedge clk);
        #1;
        if (bus.s_ready[0]) n_pkt++;
        guard++;
      end
      @(negedge clk);
      bus.s_valid = '0;
      repeat (3) @(negedge clk);
      check("stats_npkt", n_pkt, 65537);
      check("stats_pkt_cnt", pkt_cnt, 16'h0001);
    end
`endif

    check("ready_onehot", ready_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
